// File: rtl/rbs_req_arbiter_pkg.sv
// Shared definitions for the register-bus request arbiter: FSM encoding,
// default timeout read data and an index-width helper.
package rbs_req_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } rbs_state_e;

    localparam logic [31:0] RBS_TIMEOUT_RESULT = 32'hdead_beef;

    // Index width that stays legal (>= 1 bit) even for a single requester.
    function automatic int rbs_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rbs_req_arbiter_rr_select.sv
// Combinational round-robin picker: first eligible index strictly after
// last_grant, wrapping modulo NUM_REQ.
module rr_select
    import rbs_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = rbs_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    localparam int SUM_W = IDX_W + 1;

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_ok;

    // Candidate gi is the requester at offset gi+1 from the last grant.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [SUM_W-1:0] sum;
        assign sum          = {1'b0, last_grant} + SUM_W'(gi + 1);
        assign cand_idx[gi] = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                       : sum[IDX_W-1:0];
        assign cand_ok[gi]  = eligible[cand_idx[gi]];
    end

    always_comb begin
        winner = last_grant;
        valid  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_ok[k]) begin
                winner = cand_idx[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rbs_req_arbiter.sv
// Shares one udp_reg_master core_reg port between NUM_REQ requesters with
// round-robin grants, ack timeout and per-requester release tracking.
module rbs_req_arbiter
    import rbs_req_arbiter_pkg::*;
#(
    parameter int                    NUM_REQ        = 2,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 30,
    parameter int                    TIMEOUT        = 64,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_RESULT = DATA_WIDTH'(RBS_TIMEOUT_RESULT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_req,
    input  logic [NUM_REQ-1:0]               req_rd_wr_L,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wr_data,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [NUM_REQ-1:0]               req_err,
    output logic [DATA_WIDTH-1:0]            req_rd_data,
    output logic                             core_reg_req,
    output logic                             core_reg_rd_wr_L,
    output logic [ADDR_WIDTH-1:0]            core_reg_addr,
    output logic [DATA_WIDTH-1:0]            core_reg_wr_data,
    input  logic                             core_reg_ack,
    input  logic [DATA_WIDTH-1:0]            core_reg_rd_data,
    output logic [rbs_idx_w(NUM_REQ)-1:0]    grant_id,
    output logic                             busy
);

    localparam int              IDX_W    = rbs_idx_w(NUM_REQ);
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    rbs_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        grant_id_q, grant_id_d;
    logic                    core_req_q, core_req_d;
    logic                    core_rd_wr_l_q, core_rd_wr_l_d;
    logic [ADDR_WIDTH-1:0]   core_addr_q, core_addr_d;
    logic [DATA_WIDTH-1:0]   core_wr_data_q, core_wr_data_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [NUM_REQ-1:0]      err_q, err_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [NUM_REQ-1:0]      release_wait_q, release_wait_d;

    logic [ADDR_WIDTH-1:0]   addr_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wr_data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]      eligible;
    logic [IDX_W-1:0]        sel_winner;
    logic                    sel_valid;
    logic                    done;
    logic                    timed_out;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]    = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_data_arr[gi] = req_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // A requester that was just served must drop its request before it can win again.
    assign eligible = req_req & ~release_wait_q;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .eligible   (eligible),
        .last_grant (grant_id_q),
        .winner     (sel_winner),
        .valid      (sel_valid)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        grant_id_d     = grant_id_q;
        core_req_d     = core_req_q;
        core_rd_wr_l_d = core_rd_wr_l_q;
        core_addr_d    = core_addr_q;
        core_wr_data_d = core_wr_data_q;
        ack_d          = '0;
        err_d          = '0;
        rd_data_d      = rd_data_q;
        release_wait_d = release_wait_q & req_req;
        done           = 1'b0;
        timed_out      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    grant_id_d     = sel_winner;
                    core_req_d     = 1'b1;
                    core_rd_wr_l_d = req_rd_wr_L[sel_winner];
                    core_addr_d    = addr_arr[sel_winner];
                    core_wr_data_d = wr_data_arr[sel_winner];
                    cnt_d          = '0;
                    state_d        = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (core_reg_ack) begin
                    done = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (done) begin
                    state_d    = ST_IDLE;
                    core_req_d = 1'b0;
                    // A requester that withdrew mid-transaction gets no completion.
                    if (req_req[grant_id_q]) begin
                        ack_d[grant_id_q]          = 1'b1;
                        err_d[grant_id_q]          = timed_out;
                        rd_data_d                  = timed_out ? TIMEOUT_RESULT : core_reg_rd_data;
                        release_wait_d[grant_id_q] = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            grant_id_q     <= IDX_W'(NUM_REQ - 1);
            core_req_q     <= 1'b0;
            core_rd_wr_l_q <= 1'b1;
            core_addr_q    <= '0;
            core_wr_data_q <= '0;
            ack_q          <= '0;
            err_q          <= '0;
            rd_data_q      <= '0;
            release_wait_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            grant_id_q     <= grant_id_d;
            core_req_q     <= core_req_d;
            core_rd_wr_l_q <= core_rd_wr_l_d;
            core_addr_q    <= core_addr_d;
            core_wr_data_q <= core_wr_data_d;
            ack_q          <= ack_d;
            err_q          <= err_d;
            rd_data_q      <= rd_data_d;
            release_wait_q <= release_wait_d;
        end
    end

    assign req_ack          = ack_q;
    assign req_err          = err_q;
    assign req_rd_data      = rd_data_q;
    assign core_reg_req     = core_req_q;
    assign core_reg_rd_wr_L = core_rd_wr_l_q;
    assign core_reg_addr    = core_addr_q;
    assign core_reg_wr_data = core_wr_data_q;
    assign grant_id         = grant_id_q;
    assign busy             = (state_q == ST_BUSY);

endmodule

// File: tb/tb_rbs_req_arbiter.sv
// Self-checking bench for rbs_req_arbiter: scenario tasks plus a completion
// scoreboard fed when stimulus is driven and drained when req_ack pulses.
module tb_rbs_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DW      = 32;
    localparam int AW      = 30;
    localparam int TO      = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_req;
    logic [NUM_REQ-1:0]    req_rd_wr_L;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wr_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    req_err;
    logic [DW-1:0]         req_rd_data;
    logic                  core_reg_req;
    logic                  core_reg_rd_wr_L;
    logic [AW-1:0]         core_reg_addr;
    logic [DW-1:0]         core_reg_wr_data;
    logic                  core_reg_ack;
    logic [DW-1:0]         core_reg_rd_data;
    logic [0:0]            grant_id;
    logic                  busy;

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    rbs_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_req          (req_req),
        .req_rd_wr_L      (req_rd_wr_L),
        .req_addr         (req_addr),
        .req_wr_data      (req_wr_data),
        .req_ack          (req_ack),
        .req_err          (req_err),
        .req_rd_data      (req_rd_data),
        .core_reg_req     (core_reg_req),
        .core_reg_rd_wr_L (core_reg_rd_wr_L),
        .core_reg_addr    (core_reg_addr),
        .core_reg_wr_data (core_reg_wr_data),
        .core_reg_ack     (core_reg_ack),
        .core_reg_rd_data (core_reg_rd_data),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int id, input logic err, input logic [31:0] d);
        exp_t e;
        e.id   = id;
        e.err  = err;
        e.data = d;
        return e;
    endfunction

    // Scoreboard drain: every req_ack pulse must match the oldest expectation.
    task automatic monitor();
        exp_t       e;
        logic [1:0] exp_ack;
        logic [1:0] exp_err;
        forever begin
            @(negedge clk);
            if (req_ack !== 2'b00 || req_err !== 2'b00) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected: ack=%b err=%b data=%h, none expected",
                             req_ack, req_err, req_rd_data);
                end else begin
                    e       = sb_q.pop_front();
                    exp_ack = 2'b01 << e.id;
                    exp_err = e.err ? exp_ack : 2'b00;
                    if (req_ack !== exp_ack || req_err !== exp_err || req_rd_data !== e.data) begin
                        tests_failed++;
                        $display("FAIL sb_txn: got ack=%b err=%b data=%h want ack=%b err=%b data=%h",
                                 req_ack, req_err, req_rd_data, exp_ack, exp_err, e.data);
                    end else begin
                        $display("[TB] txn req%0d err=%b data=%h", e.id, e.err, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        req_req          = '0;
        req_rd_wr_L      = '1;
        req_addr         = '0;
        req_wr_data      = '0;
        core_reg_ack     = 1'b0;
        core_reg_rd_data = '0;
        repeat (3) tick();
        tests_run++;
        if (core_reg_req !== 1'b0 || core_reg_rd_wr_L !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_core_ctl: got req=%b rd_wr_L=%b want 0/1", core_reg_req, core_reg_rd_wr_L);
        end
        tests_run++;
        if (core_reg_addr !== '0 || core_reg_wr_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_core_bus: got addr=%h wdata=%h want 0/0", core_reg_addr, core_reg_wr_data);
        end
        tests_run++;
        if (req_ack !== 2'b00 || req_err !== 2'b00 || req_rd_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_req_out: got ack=%b err=%b data=%h want 0", req_ack, req_err, req_rd_data);
        end
        tests_run++;
        if (busy !== 1'b0 || grant_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b grant_id=%b want 0/1", busy, grant_id);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        req_rd_wr_L        = 2'b11;
        req_addr[AW-1:0]   = 30'h10;
        req_req            = 2'b01;
        tick();
        tests_run++;
        if (core_reg_req !== 1'b1 || core_reg_addr !== 30'h10 || core_reg_rd_wr_L !== 1'b1 || grant_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_issue: got req=%b addr=%h rd=%b gid=%b want 1/10/1/0",
                     core_reg_req, core_reg_addr, core_reg_rd_wr_L, grant_id);
        end
        repeat (4) begin
            tick();
            tests_run++;
            if (core_reg_req !== 1'b1 || core_reg_addr !== 30'h10 || req_ack !== 2'b00) begin
                tests_failed++;
                $display("FAIL single_hold: got req=%b addr=%h ack=%b want 1/10/00",
                         core_reg_req, core_reg_addr, req_ack);
            end
        end
        core_reg_ack     = 1'b1;
        core_reg_rd_data = 32'h1234_5678;
        sb_q.push_back(mk(0, 1'b0, 32'h1234_5678));
        tick();
        core_reg_ack = 1'b0;
        tests_run++;
        if (req_ack !== 2'b01 || req_rd_data !== 32'h1234_5678 || core_reg_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: got ack=%b data=%h req=%b want 01/12345678/0",
                     req_ack, req_rd_data, core_reg_req);
        end
        repeat (5) begin
            tick();
            tests_run++;
            if (core_reg_req !== 1'b0 || busy !== 1'b0 || req_rd_data !== 32'h1234_5678) begin
                tests_failed++;
                $display("FAIL single_noreissue: got req=%b busy=%b data=%h want 0/0/12345678",
                         core_reg_req, busy, req_rd_data);
            end
        end
        req_req = 2'b00;
        tick();
    endtask

    task automatic test_contention();
        int          n;
        logic        g;
        logic [31:0] d;
        reset = 1'b1;
        tick();
        reset                  = 1'b0;
        req_rd_wr_L            = 2'b11;
        req_addr[AW-1:0]       = 30'h100;
        req_addr[2*AW-1:AW]    = 30'h200;
        req_req                = 2'b11;
        for (int i = 0; i < 4; i++) begin
            g = 1'(i % 2);
            n = 0;
            while (core_reg_req !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            tests_run++;
            if (core_reg_req !== 1'b1) begin
                tests_failed++;
                $display("FAIL contention_wait: grant %0d never issued (req=%b)", i, core_reg_req);
            end
            tests_run++;
            if (grant_id !== g || core_reg_addr !== (g ? 30'h200 : 30'h100)) begin
                tests_failed++;
                $display("FAIL contention_grant: round %0d got gid=%b addr=%h want gid=%b", i, grant_id, core_reg_addr, g);
            end
            d                = $urandom();
            core_reg_ack     = 1'b1;
            core_reg_rd_data = d;
            sb_q.push_back(mk(int'(g), 1'b0, d));
            tick();
            core_reg_ack = 1'b0;
            tests_run++;
            if (req_ack !== (2'b01 << g)) begin
                tests_failed++;
                $display("FAIL contention_ack: round %0d got ack=%b want %b", i, req_ack, 2'b01 << g);
            end
            req_req = 2'b00;
            tick();
            req_req = 2'b11;
        end
        req_req = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        req_rd_wr_L      = 2'b11;
        req_addr[AW-1:0] = 30'h20;
        req_req          = 2'b01;
        sb_q.push_back(mk(0, 1'b1, 32'hdead_beef));
        tick();
        tests_run++;
        if (core_reg_req !== 1'b1 || grant_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_issue: got req=%b gid=%b want 1/0", core_reg_req, grant_id);
        end
        for (int c = 2; c <= 8; c++) begin
            tick();
            tests_run++;
            if (req_ack !== 2'b00 || core_reg_req !== 1'b1 || core_reg_addr !== 30'h20) begin
                tests_failed++;
                $display("FAIL timeout_early: cycle %0d got ack=%b req=%b addr=%h want 00/1/20",
                         c, req_ack, core_reg_req, core_reg_addr);
            end
        end
        tick();
        tests_run++;
        if (req_ack !== 2'b01 || req_err !== 2'b01 || req_rd_data !== 32'hdead_beef || core_reg_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_fire: got ack=%b err=%b data=%h req=%b want 01/01/deadbeef/0",
                     req_ack, req_err, req_rd_data, core_reg_req);
        end
        repeat (3) tick();
        core_reg_ack     = 1'b1;
        core_reg_rd_data = 32'h5555_aaaa;
        tick();
        core_reg_ack = 1'b0;
        tests_run++;
        if (req_ack !== 2'b00 || req_rd_data !== 32'hdead_beef || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_late_ack: got ack=%b data=%h busy=%b want 00/deadbeef/0",
                     req_ack, req_rd_data, busy);
        end
        req_req = 2'b00;
        tick();
    endtask

    task automatic test_abort();
        req_rd_wr_L            = 2'b01;
        req_addr[2*AW-1:AW]    = 30'h30;
        req_wr_data[2*DW-1:DW] = 32'h0000_cafe;
        req_req                = 2'b10;
        tick();
        tests_run++;
        if (grant_id !== 1'b1 || core_reg_req !== 1'b1 || core_reg_rd_wr_L !== 1'b0 ||
            core_reg_wr_data !== 32'h0000_cafe || core_reg_addr !== 30'h30) begin
            tests_failed++;
            $display("FAIL abort_issue: got gid=%b req=%b rd=%b wd=%h addr=%h want 1/1/0/cafe/30",
                     grant_id, core_reg_req, core_reg_rd_wr_L, core_reg_wr_data, core_reg_addr);
        end
        tick();
        req_req          = 2'b01;
        req_addr[AW-1:0] = 30'h40;
        tick();
        tests_run++;
        if (core_reg_addr !== 30'h30 || core_reg_rd_wr_L !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_stable: got addr=%h rd=%b busy=%b want 30/0/1", core_reg_addr, core_reg_rd_wr_L, busy);
        end
        core_reg_ack     = 1'b1;
        core_reg_rd_data = 32'h7777_7777;
        tick();
        core_reg_ack = 1'b0;
        tests_run++;
        if (req_ack !== 2'b00 || core_reg_req !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_suppress: got ack=%b req=%b busy=%b want 00/0/0", req_ack, core_reg_req, busy);
        end
        tick();
        tests_run++;
        if (core_reg_req !== 1'b1 || grant_id !== 1'b0 || core_reg_addr !== 30'h40) begin
            tests_failed++;
            $display("FAIL abort_next: got req=%b gid=%b addr=%h want 1/0/40", core_reg_req, grant_id, core_reg_addr);
        end
        core_reg_ack     = 1'b1;
        core_reg_rd_data = 32'h1357_9bdf;
        sb_q.push_back(mk(0, 1'b0, 32'h1357_9bdf));
        tick();
        core_reg_ack = 1'b0;
        tests_run++;
        if (req_ack !== 2'b01) begin
            tests_failed++;
            $display("FAIL abort_next_ack: got ack=%b want 01", req_ack);
        end
        req_req = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        req_rd_wr_L         = 2'b11;
        req_addr[2*AW-1:AW] = 30'h50;
        req_req             = 2'b10;
        tick();
        tests_run++;
        if (busy !== 1'b1 || grant_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstbusy_issue: got busy=%b gid=%b want 1/1", busy, grant_id);
        end
        tick();
        reset            = 1'b1;
        core_reg_ack     = 1'b1;
        core_reg_rd_data = 32'hffff_ffff;
        tick();
        tests_run++;
        if (core_reg_req !== 1'b0 || core_reg_rd_wr_L !== 1'b1 || core_reg_addr !== '0 ||
            core_reg_wr_data !== '0 || busy !== 1'b0 || grant_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstbusy_core: got req=%b rd=%b addr=%h wd=%h busy=%b gid=%b want 0/1/0/0/0/1",
                     core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data, busy, grant_id);
        end
        tests_run++;
        if (req_ack !== 2'b00 || req_err !== 2'b00 || req_rd_data !== '0) begin
            tests_failed++;
            $display("FAIL rstbusy_req: got ack=%b err=%b data=%h want 00/00/0", req_ack, req_err, req_rd_data);
        end
        reset            = 1'b0;
        core_reg_ack     = 1'b0;
        req_addr[AW-1:0] = 30'h58;
        req_req          = 2'b11;
        tick();
        tests_run++;
        if (core_reg_req !== 1'b1 || grant_id !== 1'b0 || core_reg_addr !== 30'h58) begin
            tests_failed++;
            $display("FAIL rstbusy_first: got req=%b gid=%b addr=%h want 1/0/58", core_reg_req, grant_id, core_reg_addr);
        end
        req_req          = 2'b01;
        core_reg_ack     = 1'b1;
        core_reg_rd_data = 32'h2468_ace0;
        sb_q.push_back(mk(0, 1'b0, 32'h2468_ace0));
        tick();
        core_reg_ack = 1'b0;
        req_req      = 2'b00;
        tick();
    endtask

    task automatic test_ack_at_timeout();
        req_rd_wr_L      = 2'b11;
        req_addr[AW-1:0] = 30'h60;
        req_req          = 2'b01;
        tick();
        repeat (7) tick();
        tests_run++;
        if (req_ack !== 2'b00 || core_reg_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_pre: got ack=%b req=%b want 00/1", req_ack, core_reg_req);
        end
        core_reg_ack     = 1'b1;
        core_reg_rd_data = 32'h0bad_f00d;
        sb_q.push_back(mk(0, 1'b0, 32'h0bad_f00d));
        tick();
        core_reg_ack = 1'b0;
        tests_run++;
        if (req_ack !== 2'b01 || req_err !== 2'b00 || req_rd_data !== 32'h0bad_f00d) begin
            tests_failed++;
            $display("FAIL same_cycle: got ack=%b err=%b data=%h want 01/00/0badf00d",
                     req_ack, req_err, req_rd_data);
        end
        req_req = 2'b00;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        fork
            monitor();
        join_none
        test_single_read();
        test_contention();
        test_timeout();
        test_abort();
        test_reset_mid_busy();
        test_ack_at_timeout();
        repeat (3) tick();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: %0d expected completions never seen, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rbs_req_arbiter.md
RBS_REQ_ARBITER -- requirements
Module: rbs_req_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of requesters sharing one udp_reg_master core_reg port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the register data width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 30, giving the word address width.
REQ-004 The block SHALL have parameter TIMEOUT, default 64, giving the maximum cycles to wait for core_reg_ack.
REQ-005 The block SHALL have parameter TIMEOUT_RESULT, default 32'hdead_beef, giving the read data returned on timeout.
REQ-006 clk  in  1  single clock; reset is synchronous and active-high.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req_req  in  NUM_REQ  per-requester level request, held until acked.
REQ-009 req_rd_wr_L  in  NUM_REQ  per-requester direction (1=read).
REQ-010 req_addr  in  NUM_REQ*ADDR_WIDTH  flattened word addresses; requester i occupies slice i.
REQ-011 req_wr_data  in  NUM_REQ*DATA_WIDTH  flattened write data.
REQ-012 req_ack  out  NUM_REQ  one-cycle completion pulse per requester.
REQ-013 req_err  out  NUM_REQ  one-cycle timeout flag, coincident with req_ack.
REQ-014 req_rd_data  out  DATA_WIDTH  read data, valid while any req_ack is high.
REQ-015 core_reg_req / core_reg_rd_wr_L / core_reg_addr / core_reg_wr_data  out  1/1/ADDR_WIDTH/DATA_WIDTH  to udp_reg_master.
REQ-016 core_reg_ack / core_reg_rd_data  in  1/DATA_WIDTH  from udp_reg_master.
REQ-017 grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-018 busy  out  1  high when state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, BUSY; all outputs registered.
REQ-020 In IDLE, the eligible set SHALL be req_req AND NOT release_wait; if non-empty, the winner SHALL be the first eligible index after grant_id, wrapping modulo NUM_REQ (round-robin).
REQ-021 On grant, the block SHALL latch the winner's rd_wr_L/addr/wr_data, update grant_id, assert core_reg_req the next cycle, and enter BUSY (latency req_req->core_reg_req = 1 cycle).
REQ-022 core_reg_* outputs SHALL stay stable throughout BUSY.
REQ-023 In BUSY, a cycle with core_reg_ack=1 SHALL produce, next cycle: req_ack[grant_id]=1, req_rd_data=registered core_reg_rd_data, core_reg_req=0, state IDLE.
REQ-024 The timeout counter SHALL clear on grant and increment each BUSY cycle; on reaching TIMEOUT-1 without ack, the next cycle SHALL give req_ack=req_err=1 for grant_id, req_rd_data=TIMEOUT_RESULT, core_reg_req=0, state IDLE.
REQ-025 Ack and timeout in the same cycle SHALL resolve as a normal ack (req_err=0).
REQ-026 On completion, release_wait[grant_id] SHALL set; it SHALL clear when that requester's req_req is low, so a held request is never re-issued.
REQ-027 If the granted requester drops req_req during BUSY, the downstream transaction SHALL still complete, but its req_ack/req_err SHALL be suppressed and release_wait SHALL not set.
REQ-028 core_reg_ack received in IDLE (late ack after timeout) SHALL be ignored.
REQ-029 req_rd_data SHALL hold its value when no req_ack is asserted; at most one req_ack bit SHALL be high per cycle.
REQ-030 Grant decisions SHALL be made only in IDLE; no back-to-back grant without one IDLE cycle.

Reset
REQ-031 Reset SHALL force: state IDLE, core_reg_req=0, core_reg_rd_wr_L=1, core_reg_addr=0, core_reg_wr_data=0, req_ack=0, req_err=0, req_rd_data=0, busy=0, release_wait=0, counter=0, grant_id=NUM_REQ-1 (so requester 0 wins first).
REQ-032 Reset asserted during BUSY SHALL abandon the transaction with no ack to any requester.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the default TIMEOUT_RESULT constant.
REQ-034 The round-robin selector SHALL be a sub-module rr_select (inputs eligible vector and last grant; outputs winner index and valid), purely combinational.

Verification
REQ-035 Single read: req_req[0]=1, addr 0x10; core_reg_ack after 5 cycles with data 0x12345678 -> core_reg_req high cycle 1, req_ack[0] and req_rd_data=0x12345678 one cycle after ack, no reissue while req_req[0] held.
REQ-036 Contention: req_req[0] and req_req[1] both held high after reset -> grants 0,1,0,1 as each drops and reasserts after ack.
REQ-037 Timeout with TIMEOUT=8: no core_reg_ack -> at cycle 9 after grant req_ack=req_err=1, req_rd_data=0xdeadbeef; late ack at cycle 12 ignored.
REQ-038 Abort: requester 1 drops req_req during BUSY -> no req_ack[1]; requester 0 granted next IDLE.
REQ-039 Reset mid-BUSY -> all outputs at reset values next cycle, no ack pulse, requester 0 granted first afterwards.
REQ-040 Simultaneous ack and timeout at count TIMEOUT-1 -> req_ack=1, req_err=0, real read data returned.
